// File: rtl/flash_region_loader_pkg.sv
// Shared definitions for the flash region loader: FSM encoding and SPI flash
// protocol constants.
package flash_region_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    CMD,
    ADR2,
    ADR1,
    ADR0,
    DATA,
    DESEL,
    FIN
  } state_t;

  localparam logic [7:0] READ_CMD     = 8'h03;
  localparam logic [7:0] DUMMY_BYTE   = 8'hFF;
  localparam int         DESEL_CYCLES = 4;
  localparam int         MAX_REGIONS  = 8;

endpackage

// File: rtl/toggle_req_port.sv
// Toggle request/acknowledge port: a transfer is pending while req != ack.
// complete pulses for one cycle when the outstanding transfer is acknowledged.
module toggle_req_port (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  input  logic ack,
  output logic req,
  output logic ready,
  output logic complete
);

  logic req_q, req_d;
  logic outstanding_q, outstanding_d;

  always_comb begin
    req_d         = req_q;
    outstanding_d = outstanding_q;
    ready         = !outstanding_q;
    complete      = outstanding_q && (req_q == ack);
    if (complete) begin
      outstanding_d = 1'b0;
    end
    if (fire && !outstanding_q) begin
      req_d         = ~req_q;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q         <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      req_q         <= req_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/flash_region_loader.sv
// Copies up to REGIONS byte ranges from SPI flash into memory, one region per
// chip-select window, through a single-byte capture buffer.
module flash_region_loader
  import flash_region_loader_pkg::*;
#(
  parameter int A_BITS   = 24,
  parameter int REGIONS  = 4,
  parameter int LEN_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   slot,
  input  logic                         start,
  input  logic [REGIONS-1:0]           region_en,
  input  logic [REGIONS*20-1:0]        region_offset,
  input  logic [REGIONS*A_BITS-1:0]    region_dest,
  input  logic [REGIONS*LEN_BITS-1:0]  region_len,
  output logic                         busy,
  output logic                         done,
  output logic                         loaded,
  output logic [2:0]                   cur_region,
  output logic                         cs_n,
  output logic                         spi_req,
  input  logic                         spi_ack,
  output logic [7:0]                   spi_d,
  input  logic [7:0]                   spi_q,
  output logic                         mem_req,
  input  logic                         mem_ack,
  output logic [A_BITS-1:0]            mem_a,
  output logic [7:0]                   mem_q
);

  state_t                        state_q, state_d;
  logic [2:0]                    idx_q, idx_d;
  logic [3:0]                    slot_q, slot_d;
  logic [REGIONS-1:0]            en_q, en_d;
  logic [REGIONS*20-1:0]         off_q, off_d;
  logic [REGIONS*A_BITS-1:0]     dest_q, dest_d;
  logic [REGIONS*LEN_BITS-1:0]   len_q, len_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          loaded_q, loaded_d;
  logic                          cs_n_q, cs_n_d;
  logic [7:0]                    spi_d_q, spi_d_d;
  logic [A_BITS-1:0]             mem_a_q, mem_a_d;
  logic [7:0]                    mem_q_q, mem_q_d;
  logic [LEN_BITS-1:0]           sent_q, sent_d;
  logic [LEN_BITS-1:0]           rcv_q, rcv_d;
  logic [LEN_BITS-1:0]           wr_q, wr_d;
  logic [2:0]                    desel_q, desel_d;
  logic                          buf_full_q, buf_full_d;
  logic [7:0]                    buf_q, buf_d;

  logic spi_fire, spi_ready, spi_complete;
  logic mem_fire, mem_ready, mem_complete;
  logic capture;

  // Descriptors padded to eight entries so a 3-bit index always selects a slot.
  logic                en_arr   [MAX_REGIONS];
  logic [19:0]         off_arr  [MAX_REGIONS];
  logic [A_BITS-1:0]   dest_arr [MAX_REGIONS];
  logic [LEN_BITS-1:0] len_arr  [MAX_REGIONS];

  for (genvar gi = 0; gi < MAX_REGIONS; gi++) begin : g_desc
    if (gi < REGIONS) begin : g_used
      assign en_arr[gi]   = en_q[gi];
      assign off_arr[gi]  = off_q[gi*20 +: 20];
      assign dest_arr[gi] = dest_q[gi*A_BITS +: A_BITS];
      assign len_arr[gi]  = len_q[gi*LEN_BITS +: LEN_BITS];
    end else begin : g_unused
      assign en_arr[gi]   = 1'b0;
      assign off_arr[gi]  = '0;
      assign dest_arr[gi] = '0;
      assign len_arr[gi]  = '0;
    end
  end

  logic                cur_en;
  logic [LEN_BITS-1:0] cur_len;
  logic [A_BITS-1:0]   cur_dest;
  logic [23:0]         flash_addr;

  assign cur_en     = en_arr[idx_q];
  assign cur_len    = len_arr[idx_q];
  assign cur_dest   = dest_arr[idx_q];
  assign flash_addr = {slot_q, off_arr[idx_q]};

  toggle_req_port u_spi_port (
    .clk      (clk),
    .reset    (reset),
    .fire     (spi_fire),
    .ack      (spi_ack),
    .req      (spi_req),
    .ready    (spi_ready),
    .complete (spi_complete)
  );

  toggle_req_port u_mem_port (
    .clk      (clk),
    .reset    (reset),
    .fire     (mem_fire),
    .ack      (mem_ack),
    .req      (mem_req),
    .ready    (mem_ready),
    .complete (mem_complete)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    en_d       = en_q;
    off_d      = off_q;
    dest_d     = dest_q;
    len_d      = len_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    loaded_d   = loaded_q;
    cs_n_d     = cs_n_q;
    spi_d_d    = spi_d_q;
    mem_a_d    = mem_a_q;
    mem_q_d    = mem_q_q;
    sent_d     = sent_q;
    rcv_d      = rcv_q;
    wr_d       = wr_q;
    desel_d    = desel_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    spi_fire   = 1'b0;
    mem_fire   = 1'b0;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          slot_d   = slot;
          en_d     = region_en;
          off_d    = region_offset;
          dest_d   = region_dest;
          len_d    = region_len;
          loaded_d = 1'b0;
          busy_d   = 1'b1;
          idx_d    = 3'd0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (cur_en && (cur_len != '0)) begin
          cs_n_d  = 1'b0;
          sent_d  = '0;
          rcv_d   = '0;
          wr_d    = '0;
          state_d = CMD;
        end else if (idx_q == 3'(REGIONS - 1)) begin
          done_d   = 1'b1;
          loaded_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = FIN;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      CMD: begin
        spi_fire = spi_ready;
        if (spi_ready) spi_d_d = READ_CMD;
        if (spi_complete) state_d = ADR2;
      end
      ADR2: begin
        spi_fire = spi_ready;
        if (spi_ready) spi_d_d = flash_addr[23:16];
        if (spi_complete) state_d = ADR1;
      end
      ADR1: begin
        spi_fire = spi_ready;
        if (spi_ready) spi_d_d = flash_addr[15:8];
        if (spi_complete) state_d = ADR0;
      end
      ADR0: begin
        spi_fire = spi_ready;
        if (spi_ready) spi_d_d = flash_addr[7:0];
        if (spi_complete) state_d = DATA;
      end
      DATA: begin
        // A new byte is only requested into an empty buffer, so a capture can
        // never overwrite a byte that has not yet been handed to memory.
        if (spi_ready && !buf_full_q && (sent_q != cur_len)) begin
          spi_fire = 1'b1;
          spi_d_d  = DUMMY_BYTE;
          sent_d   = sent_q + 1'b1;
        end
        capture = spi_complete;
        if ((rcv_q == cur_len) && !buf_full_q && mem_ready) begin
          cs_n_d  = 1'b1;
          desel_d = 3'd0;
          state_d = DESEL;
        end
      end
      DESEL: begin
        desel_d = desel_q + 3'd1;
        if (desel_q == 3'(DESEL_CYCLES - 1)) begin
          if (idx_q == 3'(REGIONS - 1)) begin
            done_d   = 1'b1;
            loaded_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = FIN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SCAN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_fire = buf_full_q && mem_ready;
    if (mem_fire) begin
      mem_a_d    = cur_dest + A_BITS'(wr_q);
      mem_q_d    = buf_q;
      wr_d       = wr_q + 1'b1;
      buf_full_d = 1'b0;
    end
    if (capture) begin
      buf_d      = spi_q;
      buf_full_d = 1'b1;
      rcv_d      = rcv_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      slot_q     <= '0;
      en_q       <= '0;
      off_q      <= '0;
      dest_q     <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      spi_d_q    <= DUMMY_BYTE;
      mem_a_q    <= '0;
      mem_q_q    <= '0;
      sent_q     <= '0;
      rcv_q      <= '0;
      wr_q       <= '0;
      desel_q    <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      en_q       <= en_d;
      off_q      <= off_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
      cs_n_q     <= cs_n_d;
      spi_d_q    <= spi_d_d;
      mem_a_q    <= mem_a_d;
      mem_q_q    <= mem_q_d;
      sent_q     <= sent_d;
      rcv_q      <= rcv_d;
      wr_q       <= wr_d;
      desel_q    <= desel_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign loaded     = loaded_q;
  assign cur_region = busy_q ? idx_q : 3'd0;
  assign cs_n       = cs_n_q;
  assign spi_d      = spi_d_q;
  assign mem_a      = mem_a_q;
  assign mem_q      = mem_q_q;

endmodule

// File: doc/flash_region_loader.md
FLASH_REGION_LOADER -- requirements
Module: flash_region_loader

Interface
REQ-001 Parameter A_BITS, default 24: destination memory address width.
REQ-002 Parameter REGIONS, default 4: number of region descriptors, range 1..8.
REQ-003 Parameter LEN_BITS, default 16: region byte-count width.
REQ-004 clk  in  1  system clock; the block uses this one clock only.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 slot  in  4  flash slot; flash byte address = {slot, offset[19:0]}.
REQ-007 start  in  1  single-cycle load request.
REQ-008 region_en  in  REGIONS  per-region enable.
REQ-009 region_offset  in  REGIONS*20  per-region flash offset within the slot.
REQ-010 region_dest  in  REGIONS*A_BITS  per-region destination start address.
REQ-011 region_len  in  REGIONS*LEN_BITS  per-region byte count.
REQ-012 busy  out  1  load in progress.
REQ-013 done  out  1  one-cycle pulse when a load sequence finishes.
REQ-014 loaded  out  1  sticky; set at done; cleared by reset or by an accepted start.
REQ-015 cur_region  out  3  index of the region being loaded.
REQ-016 cs_n  out  1  flash chip select, active low.
REQ-017 spi_req / spi_ack  out / in  1 / 1  toggle handshake; a byte transfer is pending while req != ack.
REQ-018 spi_d / spi_q  out / in  8 / 8  byte to send / byte received (spi_q valid when ack equals req).
REQ-019 mem_req / mem_ack  out / in  1 / 1  toggle write handshake; a write is pending while req != ack.
REQ-020 mem_a / mem_q  out / out  A_BITS / 8  write address / write data, stable while pending.

Function
REQ-021 FSM states: IDLE, SCAN, CMD, ADR2, ADR1, ADR0, DATA, DESEL, FIN.
REQ-022 IDLE: start accepts, latches all descriptors and slot, clears loaded, sets busy next cycle, and sets region index to 0, then goes to SCAN.
REQ-023 A start asserted while busy is ignored.
REQ-024 SCAN: a region with en=1 and len≠0 goes to CMD with cs_n=0; otherwise the index increments; after the index passes REGIONS-1, the FSM goes to FIN.
REQ-025 A disabled or zero-length region produces no SPI or memory traffic.
REQ-026 CMD, ADR2, ADR1 and ADR0 each send one byte: 0x03, address[23:16], address[15:8], address[7:0].
REQ-027 Each byte is sent by toggling spi_req, and the FSM waits for spi_ack == spi_req before advancing.
REQ-028 DATA sends 0xFF and captures spi_q into a one-byte buffer when the transfer completes.
REQ-029 The buffer issues a memory write by toggling mem_req, with mem_a = dest + byte count modulo 2^A_BITS.
REQ-030 The next SPI DATA transfer may start while a memory write is pending; the FSM shall not complete a new capture while the buffer is still occupied (stall).
REQ-031 After len bytes are captured and the last memory write is acknowledged, the FSM goes to DESEL.
REQ-032 DESEL: cs_n=1 for exactly 4 clk cycles, then the index increments and the FSM returns to SCAN.
REQ-033 FIN: done=1 for one cycle, loaded=1, busy=0, then IDLE.
REQ-034 Address arithmetic: the destination wraps silently at 2^A_BITS; the flash offset wraps at 2^20 within the slot.
REQ-035 The maximum region length is 2^LEN_BITS-1 bytes.
REQ-036 cs_n stays low for the whole region, from CMD through the last DATA transfer.
REQ-037 cur_region holds the current region index while busy and 0 while idle.

Reset
REQ-038 Reset forces: state IDLE, busy=0, done=0, loaded=0, cs_n=1, spi_req=0, mem_req=0, spi_d=0xFF, mem_a=0, mem_q=0, cur_region=0, buffer empty.
REQ-039 Reset mid-operation abandons the load; no further req toggles occur until a new start is accepted.

Structure
REQ-040 A shared package holds the state enumeration, the read-command constant 0x03, the dummy byte 0xFF, and the deselect cycle count 4.
REQ-041 One sub-module, toggle_req_port, encapsulates toggle-handshake pending/complete detection; it is instantiated twice (SPI and memory).

Verification
REQ-042 Single region: slot=2, region 0 with offset 0x00100, dest 0x8000, len 4 -> SPI bytes 03 20 01 00 FF FF FF FF; writes to 0x8000..0x8003; one done pulse; loaded=1.
REQ-043 Regions 0 and 2 enabled, region 1 with len=0, region 3 disabled -> exactly two cs_n low windows separated by ≥4 cycles high; cur_region goes 0 then 2.
REQ-044 mem_ack delayed 20 cycles per write -> no more than one buffered byte outstanding, no byte lost or duplicated, data order preserved.
REQ-045 dest 0xFFFFFE, len 4 -> write addresses FFFFFE, FFFFFF, 000000, 000001.
REQ-046 Reset asserted during the third DATA byte -> cs_n=1 and busy=0 immediately, req outputs 0, no done pulse; a subsequent start performs a full load.
REQ-047 start pulsed again while busy -> ignored; exactly one done pulse.
